// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg -- shared types and constants for the instruction-memory arbiter.
//
// Contents:
//   state_e                      controller states (S_INIT, S_PRELOAD, S_IDLE)
//   IMEM_AW / IMEM_DW / IMEM_DEPTH   default address width, data width, depth
//   NUM_REQ, REQ_LD, REQ_IF      requester count and grant-vector indices
//   in_range()                   address-within-implemented-depth helper
//
// Build option: IMEM_ARB_RR_EN (see imem_rr_arb) selects round-robin arbitration.
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_AW    = 16;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_DEPTH = 256;

  // Requester indices into the two-bit grant vector.
  localparam int NUM_REQ = 2;
  localparam int REQ_LD  = 0;
  localparam int REQ_IF  = 1;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_PRELOAD = 2'd1,
    S_IDLE    = 2'd2
  } state_e;

  // Addresses at or above the implemented depth have no backing word.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/imem_rr_arb.sv
// -----------------------------------------------------------------------------
// imem_rr_arb -- two-way arbiter between the program loader and the fetch port.
//
// Build option IMEM_ARB_RR_EN:
//   undefined : fixed priority, the loader always wins a conflict; purely
//               combinational, no clock or reset ports.
//   defined   : a 1-bit last-winner register alternates priority on conflict.
//               It resets to "fetch last", so the loader wins the first
//               conflict. Every issued grant updates it.
//
// Ports:
//   clk, reset   (IMEM_ARB_RR_EN only) clock and async active-low reset
//   en           arbitration enabled (controller idle)
//   ld_req       loader request
//   if_req       fetch request
//   gnt          one-hot-or-zero grant vector, indexed by REQ_LD / REQ_IF
// -----------------------------------------------------------------------------
module imem_rr_arb
  import imem_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
  input  logic               clk,
  input  logic               reset,
`endif
  input  logic               en,
  input  logic               ld_req,
  input  logic               if_req,
  output logic [NUM_REQ-1:0] gnt
);

  logic ld_win;

`ifdef IMEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  always_comb begin
    // Loader wins when uncontested, or on conflict when fetch won last time.
    ld_win          = ld_req & (~if_req | (last_q == 1'(REQ_IF)));
    gnt             = '0;
    gnt[REQ_LD]     = en & ld_win;
    gnt[REQ_IF]     = en & if_req & ~ld_win;
    last_d          = last_q;
    if (gnt[REQ_LD]) begin
      last_d = 1'(REQ_LD);
    end else if (gnt[REQ_IF]) begin
      last_d = 1'(REQ_IF);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'(REQ_IF);
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    ld_win      = ld_req;
    gnt         = '0;
    gnt[REQ_LD] = en & ld_win;
    gnt[REQ_IF] = en & if_req & ~ld_win;
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter -- sequencer and port arbiter in front of a synchronous
// instruction memory. After every reset it pulses mem_reset for one cycle so
// the memory reloads its program image, then arbitrates loader writes against
// fetch reads (one grant per cycle) and returns fetch data one cycle later.
//
// Build option IMEM_ARB_RR_EN: round-robin instead of fixed loader priority
// (implemented in imem_rr_arb).
//
// Parameters: AW address width, DW data width, DEPTH implemented words.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   ld_req/ld_addr/ld_data/ld_gnt   loader write port
//   if_req/if_addr/if_gnt           fetch request port
//   if_valid/if_data/if_err         fetch return (one cycle after if_gnt)
//   mem_write/mem_addr/mem_datain   memory command
//   mem_dataout                     registered memory read data
//   mem_reset                       one-cycle program preload pulse
//   busy                            controller not yet idle
// -----------------------------------------------------------------------------
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_gnt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_data,
  output logic          if_err,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout,
  output logic          mem_reset,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          mem_reset_q, mem_reset_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_err_q, rd_err_d;

  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic               ld_in_range;
  logic               if_in_range;

  // ---------------------------------------------------------------------------
  // Sequencer: INIT -> PRELOAD -> IDLE after every reset release.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:    state_d = S_PRELOAD;
      S_PRELOAD: state_d = S_IDLE;
      S_IDLE:    state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
    // Registered so the pulse lines up exactly with the PRELOAD state.
    mem_reset_d = (state_d == S_PRELOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      mem_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_reset_q <= mem_reset_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration (grants are combinational from requests and state).
  // ---------------------------------------------------------------------------
  assign arb_en = (state_q == S_IDLE);

  imem_rr_arb u_arb (
`ifdef IMEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .en     (arb_en),
    .ld_req (ld_req),
    .if_req (if_req),
    .gnt    (gnt)
  );

  assign ld_gnt = gnt[REQ_LD];
  assign if_gnt = gnt[REQ_IF];

  assign ld_in_range = in_range(32'(ld_addr), DEPTH);
  assign if_in_range = in_range(32'(if_addr), DEPTH);

  // ---------------------------------------------------------------------------
  // Memory command. Out-of-range loader writes are granted (so the loader
  // moves on) but never reach the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_write  = ld_gnt & ld_in_range;
    mem_datain = ld_gnt ? ld_data : '0;
    mem_addr_d = mem_addr_q;
    if (ld_gnt) begin
      mem_addr_d = ld_addr;
    end else if (if_gnt) begin
      mem_addr_d = if_addr;
    end
    mem_addr = mem_addr_d;
  end

  // ---------------------------------------------------------------------------
  // Fetch return pipeline: one stage, matching the memory's registered read.
  // The error flag is captured with the grant so the return cycle does not
  // depend on the (possibly changed) request address.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_pend_d = if_gnt;
    rd_err_d  = if_gnt & ~if_in_range;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign if_valid  = rd_pend_q;
  assign if_err    = rd_pend_q & rd_err_q;
  assign if_data   = (rd_pend_q & ~rd_err_q) ? mem_dataout : '0;
  assign mem_reset = mem_reset_q;
  // Gated by reset so busy reads 0 while reset is held, even though the
  // state register sits in S_INIT then.
  assign busy      = reset & (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter -- self-checking bench for imem_arbiter.
// Contains a 256-word memory that reloads a fixed program image on mem_reset,
// a cycle-level behavioural model of the arbiter's rules, a compare process
// that checks every output at each falling edge, and directed stimulus with
// hand-computed literal expectations. Honours IMEM_ARB_RR_EN.
// Inputs are driven 2 time units after the rising edge; outputs are sampled
// at the falling edge.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_gnt;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_data;
  logic          if_err;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout = '0;
  logic          mem_reset;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  imem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_valid    (if_valid),
    .if_data     (if_data),
    .if_err      (if_err),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout),
    .mem_reset   (mem_reset),
    .busy        (busy)
  );

  function automatic logic [31:0] pre_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // ---------------------------------------------------------------- memory
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_word(i);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_datain;
    end
    mem_dataout <= mem[mem_addr[7:0]];
  end

  // ----------------------------------------------------------------- model
  // m_phase: cycles since reset release (0 = init, 1 = preload, 2 = ready).
  int            m_phase = 0;
  bit            m_pend = 1'b0;
  bit            m_err = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  bit            m_fetch_last = 1'b1;
  logic [DW-1:0] shadow [DEPTH];

  // 0 = nobody, 1 = loader, 2 = fetch
  function automatic int winner(input int phase, input bit lr, input bit fr, input bit fetch_last);
    if (phase < 2) return 0;
    if (lr && fr) return (RR && !fetch_last) ? 2 : 1;
    if (lr) return 1;
    if (fr) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase      <= 0;
      m_pend       <= 1'b0;
      m_err        <= 1'b0;
      m_addr       <= '0;
      m_fetch_last <= 1'b1;
    end else begin
      int w;
      w = winner(m_phase, ld_req, if_req, m_fetch_last);
      m_phase <= (m_phase < 2) ? m_phase + 1 : 2;
      if (m_phase == 1) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] <= pre_word(i);
      end
      m_pend <= (w == 2);
      m_err  <= (w == 2) && (int'(if_addr) >= DEPTH);
      if (w == 2) m_rdata <= shadow[if_addr[7:0]];
      if (w == 1) begin
        m_addr       <= ld_addr;
        m_fetch_last <= 1'b0;
        if (int'(ld_addr) < DEPTH) shadow[ld_addr[7:0]] <= ld_data;
      end else if (w == 2) begin
        m_addr       <= if_addr;
        m_fetch_last <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // -------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (cmp_on) begin
      int w;
      logic [AW-1:0] e_addr;
      w = reset ? winner(m_phase, ld_req, if_req, m_fetch_last) : 0;
      e_addr = (w == 1) ? ld_addr : (w == 2) ? if_addr : m_addr;
      chk("m_ld_gnt",    32'(ld_gnt),    32'(w == 1));
      chk("m_if_gnt",    32'(if_gnt),    32'(w == 2));
      chk("m_mem_write", 32'(mem_write), 32'((w == 1) && (int'(ld_addr) < DEPTH)));
      chk("m_mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("m_mem_datain", mem_datain,    (w == 1) ? ld_data : 32'h0);
      chk("m_mem_reset", 32'(mem_reset), 32'(reset && m_phase == 1));
      chk("m_busy",      32'(busy),      32'(reset && m_phase != 2));
      chk("m_if_valid",  32'(if_valid),  32'(m_pend));
      chk("m_if_err",    32'(if_err),    32'(m_pend && m_err));
      chk("m_if_data",   if_data,        (m_pend && !m_err) ? m_rdata : 32'h0);
      $display("cyc t=%0t rst=%b ld=%b/%h if=%b/%h gnt=%b%b maddr=%h we=%b mrst=%b busy=%b v=%b d=%h e=%b",
               $time, reset, ld_req, ld_addr, if_req, if_addr, ld_gnt, if_gnt,
               mem_addr, mem_write, mem_reset, busy, if_valid, if_data, if_err);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic drive(input bit lr, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit fr, input logic [AW-1:0] fa);
    @(posedge clk);
    #2;
    ld_req  = lr;
    ld_addr = la;
    ld_data = ld;
    if_req  = fr;
    if_addr = fa;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    @(posedge clk);
    cmp_on = 1'b1;

    // Requests during reset must not be granted.
    repeat (3) drive(1'b1, 16'd5, 32'h55, 1'b1, 16'd3);
    chk("rst_ld_gnt",    32'(ld_gnt),    32'd0);
    chk("rst_if_gnt",    32'(if_gnt),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_mem_reset", 32'(mem_reset), 32'd0);

    // Release: init, preload, then fetch addr 0 granted in the third cycle.
    @(posedge clk);
    #2;
    reset = 1'b1; ld_req = 1'b0; if_req = 1'b1; if_addr = 16'd0;
    @(negedge clk);
    chk("c1_busy",      32'(busy),      32'd1);
    chk("c1_mem_reset", 32'(mem_reset), 32'd0);
    chk("c1_if_gnt",    32'(if_gnt),    32'd0);
    drive(1'b0, '0, '0, 1'b1, 16'd0);
    chk("c2_mem_reset", 32'(mem_reset), 32'd1);
    chk("c2_if_gnt",    32'(if_gnt),    32'd0);
    drive(1'b0, '0, '0, 1'b1, 16'd0);
    chk("c3_busy",      32'(busy),      32'd0);
    chk("c3_mem_reset", 32'(mem_reset), 32'd0);
    chk("c3_if_gnt",    32'(if_gnt),    32'd1);

    // Back-to-back fetches 1..5; each cycle returns the previous address.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i));
      chk("burst_valid", 32'(if_valid), 32'd1);
      chk("burst_data",  if_data,       32'hC0DE_0000 + 32'(i - 1));
    end
    idle();
    chk("burst_last_data", if_data, 32'hC0DE_0005);
    idle();
    chk("burst_done_valid", 32'(if_valid), 32'd0);

    // Conflict: loader first, then the held fetch; fetch sees the new word.
    drive(1'b1, 16'd10, 32'h1111_1111, 1'b1, 16'd10);
    chk("conf_ld_gnt",    32'(ld_gnt),    32'd1);
    chk("conf_if_gnt",    32'(if_gnt),    32'd0);
    chk("conf_mem_write", 32'(mem_write), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 16'd10);
    chk("conf_if_gnt2",   32'(if_gnt),    32'd1);
    idle();
    chk("conf_rdata",     if_data,        32'h1111_1111);

    // Write then immediate read of the same address.
    drive(1'b1, 16'd7, 32'hDEAD_BEEF, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b1, 16'd7);
    idle();
    chk("raw_data", if_data, 32'hDEAD_BEEF);
    chk("raw_err",  32'(if_err), 32'd0);

    // Four conflicting cycles after a fetch win.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'd20, 32'h2222_0000 + 32'(k), 1'b1, 16'd20);
      chk("rr_ld_gnt", 32'(ld_gnt), RR ? 32'((k % 2) == 0) : 32'd1);
      chk("rr_if_gnt", 32'(if_gnt), RR ? 32'((k % 2) == 1) : 32'd0);
    end
    idle();
    idle();

    // Out-of-range fetch, then the last in-range word.
    drive(1'b0, '0, '0, 1'b1, 16'h0100);
    chk("oor_if_gnt", 32'(if_gnt), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 16'h00FF);
    chk("oor_valid", 32'(if_valid), 32'd1);
    chk("oor_err",   32'(if_err),   32'd1);
    chk("oor_data",  if_data,       32'h0);
    idle();
    chk("top_err",  32'(if_err), 32'd0);
    chk("top_data", if_data,     32'hC0DE_00FF);

    // Out-of-range write: granted, no strobe, address then held.
    drive(1'b1, 16'h0100, 32'hBAD0_BAD0, 1'b0, '0);
    chk("oorw_ld_gnt",    32'(ld_gnt),    32'd1);
    chk("oorw_mem_write", 32'(mem_write), 32'd0);
    idle();
    chk("hold_mem_addr",  32'(mem_addr),  32'h0000_0100);
    drive(1'b0, '0, '0, 1'b1, 16'd0);
    idle();
    chk("noalias_data", if_data, 32'hC0DE_0000);

    // Reset during an in-flight fetch drops it; preload runs again.
    drive(1'b0, '0, '0, 1'b1, 16'd7);
    chk("mid_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("mid_no_valid", 32'(if_valid), 32'd0);
    idle();
    idle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("re_c1_busy",      32'(busy),      32'd1);
    chk("re_c1_mem_reset", 32'(mem_reset), 32'd0);
    idle();
    chk("re_c2_mem_reset", 32'(mem_reset), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 16'd7);
    chk("re_c3_busy",   32'(busy),   32'd0);
    chk("re_c3_if_gnt", 32'(if_gnt), 32'd1);
    idle();
    chk("re_preload_data", if_data, 32'hC0DE_0007);
    idle();
    idle();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
